// File: rtl/wb_port_arbiter_pkg.sv
// Shared parameters, state encoding and request type for the writeback
// port arbiter and its pending queue.
package wb_port_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        WB_PIPE_PRI = 1'b0,
        WB_DRAIN    = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between writeback, the long-latency result path and the
// register-file write port. The arbiter takes the slave view.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic            pipe_valid;
    logic [AW-1:0]   pipe_addr;
    logic [XLEN-1:0] pipe_data;
    logic            pipe_ready;

    logic            ll_valid;
    logic [AW-1:0]   ll_addr;
    logic [XLEN-1:0] ll_data;
    logic            ll_ready;

    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    modport slave (
        input  pipe_valid, pipe_addr, pipe_data,
        input  ll_valid, ll_addr, ll_data,
        output pipe_ready, ll_ready,
        output rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output pipe_valid, pipe_addr, pipe_data,
        output ll_valid, ll_addr, ll_data,
        input  pipe_ready, ll_ready,
        input  rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_port_arbiter_pend_fifo.sv
// Pending queue for long-latency results: circular buffer with a live bit
// per entry and a parallel address compare that kills matching entries.
module wb_port_arbiter_pend_fifo
    import wb_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [AW-1:0]    push_addr_i,
    input  logic [XLEN-1:0]  push_data_i,
    input  logic             pop_i,
    input  logic             squash_en_i,
    input  logic [AW-1:0]    squash_addr_i,
    output logic [AW-1:0]    head_addr_o,
    output logic [XLEN-1:0]  head_data_o,
    output logic             head_live_o,
    output logic [CNT_W-1:0] count_o
);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [DEPTH-1:0] live_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_killed;

    // An entry pushed in the same cycle as a matching pipe write is older
    // than that write, so it enters already dead.
    assign push_killed = squash_en_i && (push_addr_i == squash_addr_i);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_live
            assign live_d[gi] = (push_i && (wr_ptr_q == PTR_W'(gi)))
                              ? !push_killed
                              : (live_q[gi] && !(squash_en_i && (addr_mem[gi] == squash_addr_i)));
        end
    endgenerate

    // Payload storage; contents only matter while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_mem[wr_ptr_q] <= push_addr_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and live bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q  <= live_d;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign head_addr_o = addr_mem[rd_ptr_q];
    assign head_data_o = data_mem[rd_ptr_q];
    assign head_live_o = live_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback has priority, long-latency
// results wait in a small queue that is drained when full or aged out.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    wb_port_arbiter_if.slave wb,
    output logic [CNT_W-1:0] pend_cnt_o,
    output logic             drain_o
);

    wb_state_e        state_q;
    logic [WAIT_W-1:0] wait_q;
    logic             rf_we_q;
    logic [AW-1:0]    rf_waddr_q;
    logic [XLEN-1:0]  rf_wdata_q;

    logic [AW-1:0]    head_addr;
    logic [XLEN-1:0]  head_data;
    logic             head_live;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             has_head, head_ok, pipe_grant, head_grant;
    logic             pop, push, ll_ready, aged;
    wb_req_t          grant_req;

    assign has_head   = (count != '0);
    assign head_ok    = has_head && head_live;
    // Pipe writes to x0 complete the handshake but leave the port free.
    assign pipe_grant = (state_q == WB_PIPE_PRI) && wb.pipe_valid && (wb.pipe_addr != '0);
    assign head_grant = head_ok && ((state_q == WB_DRAIN) || !pipe_grant);
    // Dead heads retire without touching the port.
    assign pop        = has_head && (head_grant || !head_live);
    assign ll_ready   = (count < CNT_W'(DEPTH));
    assign push       = wb.ll_valid && ll_ready && (wb.ll_addr != '0);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign aged       = head_ok && !head_grant && (wait_q == WAIT_W'(MAX_WAIT - 1));

    wb_port_arbiter_pend_fifo u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (push),
        .push_addr_i   (wb.ll_addr),
        .push_data_i   (wb.ll_data),
        .pop_i         (pop),
        .squash_en_i   (pipe_grant),
        .squash_addr_i (wb.pipe_addr),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .head_live_o   (head_live),
        .count_o       (count)
    );

    // Select the winning write; the two grants are mutually exclusive.
    always_comb begin
        grant_req = '{addr: head_addr, data: head_data};
        if (pipe_grant) grant_req = '{addr: wb.pipe_addr, data: wb.pipe_data};
    end

    // Arbitration FSM, head ageing counter and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WB_PIPE_PRI;
            wait_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= pipe_grant || head_grant;
            if (pipe_grant || head_grant) begin
                rf_waddr_q <= grant_req.addr;
                rf_wdata_q <= grant_req.data;
            end
            wait_q <= (head_ok && !head_grant) ? wait_q + WAIT_W'(1) : '0;
            case (state_q)
                WB_PIPE_PRI: if ((count_next == CNT_W'(DEPTH)) || aged) state_q <= WB_DRAIN;
                WB_DRAIN:    if (count_next == '0) state_q <= WB_PIPE_PRI;
                default:     state_q <= WB_PIPE_PRI;
            endcase
        end
    end

    assign wb.pipe_ready = (state_q == WB_PIPE_PRI);
    assign wb.ll_ready   = ll_ready;
    assign wb.rf_we      = rf_we_q;
    assign wb.rf_waddr   = rf_waddr_q;
    assign wb.rf_wdata   = rf_wdata_q;
    assign pend_cnt_o    = count;
    assign drain_o       = (state_q == WB_DRAIN);

endmodule
